pattern_scan_sched: RTL

//  Schedules one shared 10110 pattern-detector engine between two frame requesters.
//  - Takes a FRAME_W-bit frame from the round-robin winner.
//  - Resets the detector, then streams the frame MSB-first on det_d/det_valid.
//  - Counts det_pattern pulses and returns {id, count} on a valid/ready result port.

---
 rtl/pattern_sched_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 15 +
 rtl/pattern_scan_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pattern_sched_pkg.sv
// Shared encodings and constants for the 10110 scan scheduler.
// One-hot FSM states, pattern constants and counter width helper.
package pattern_sched_pkg;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_CLR   = 5'b00010,
    S_SHIFT = 5'b00100,
    S_DRAIN = 5'b01000,
    S_RESP  = 5'b10000
  } state_t;

  localparam int I_IDLE  = 0;
  localparam int I_CLR   = 1;
  localparam int I_SHIFT = 2;
  localparam int I_DRAIN = 3;
  localparam int I_RESP  = 4;

  localparam int PAT_LEN = 5;
  localparam logic [PAT_LEN-1:0] PAT = 5'b10110;

  function automatic int bcnt_w(input int fw);
    return $clog2(fw + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// The requester that did not own the last result wins a tie.
module rr_arb2 (
  input  logic       v0_i,
  input  logic       v1_i,
  input  logic       last_id_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  assign gnt_o[0] = v0_i & (~v1_i | last_id_i);
  assign gnt_o[1] = v1_i & (~v0_i | ~last_id_i);
  assign gnt_id_o = gnt_o[1];

endmodule

// File: rtl/pattern_scan_sched.sv
// Shares one external 10110 detector between two frame requesters.
// Streams the granted frame MSB-first and returns the match count.
module pattern_scan_sched
  import pattern_sched_pkg::*;
#(
  parameter int FRAME_W = 16,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [FRAME_W-1:0] req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [FRAME_W-1:0] req1_data,
  output logic               req1_ready,
  output logic               det_rst,
  output logic               det_d,
  output logic               det_valid,
  input  logic               det_pattern,
  output logic               res_valid,
  output logic               res_id,
  output logic [CNT_W-1:0]   res_count,
  input  logic               res_ready,
  output logic               busy
);

  localparam int BW = bcnt_w(FRAME_W);
  localparam logic [BW-1:0] BLAST = BW'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [BW-1:0]      bc_q, bc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               id_q, id_d;
  logic               last_q, last_d;
  logic               hold_q;
  logic [1:0]         gnt;
  logic               gnt_id;

  rr_arb2 u_arb (
    .v0_i      (req0_valid),
    .v1_i      (req1_valid),
    .last_id_i (last_q),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bc_d    = bc_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (!hold_q && gnt != 2'b00) begin
          sh_d    = gnt_id ? req1_data : req0_data;
          id_d    = gnt_id;
          cnt_d   = '0;
          state_d = S_CLR;
        end
      end
      state_q[I_CLR]: begin
        bc_d    = '0;
        state_d = S_SHIFT;
      end
      state_q[I_SHIFT]: begin
        sh_d = {sh_q[FRAME_W-2:0], 1'b0};
        bc_d = bc_q + 1'b1;
        if (det_pattern && cnt_q != CMAX)
          cnt_d = cnt_q + 1'b1;
        if (bc_q == BLAST)
          state_d = S_DRAIN;
      end
      state_q[I_DRAIN]: begin
        if (det_pattern && cnt_q != CMAX)
          cnt_d = cnt_q + 1'b1;
        state_d = S_RESP;
      end
      state_q[I_RESP]: begin
        if (res_ready) begin
          last_d  = id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // hold_q keeps the detector in reset until the first edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bc_q    <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bc_q    <= bc_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      hold_q  <= 1'b0;
    end
  end

  assign busy       = ~state_q[I_IDLE];
  assign req0_ready = state_q[I_IDLE] & ~hold_q & gnt[0];
  assign req1_ready = state_q[I_IDLE] & ~hold_q & gnt[1];
  assign det_rst    = hold_q | state_q[I_CLR];
  assign det_valid  = state_q[I_SHIFT];
  assign det_d      = state_q[I_SHIFT] & sh_q[FRAME_W-1];
  assign res_valid  = state_q[I_RESP];
  assign res_id     = state_q[I_RESP] & id_q;
  assign res_count  = state_q[I_RESP] ? cnt_q : '0;

endmodule
